// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension,
// and request legality/alignment checks.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  req_f3,
    input  logic [1:0]  req_off,
    input  logic [31:0] store_data,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] sh;

    always_comb begin
        wstrb      = 4'b0000;
        wdata      = store_data;
        misaligned = 1'b0;
        illegal    = 1'b0;
        unique case (req_f3)
            F3_B: begin
                wstrb = 4'b0001 << req_off;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                wstrb      = 4'b0011 << req_off;
                wdata      = {2{store_data[15:0]}};
                misaligned = req_off[0];
            end
            F3_W: begin
                wstrb      = 4'b1111;
                misaligned = |req_off;
            end
            F3_BU: illegal = is_store;
            F3_HU: begin
                illegal    = is_store;
                misaligned = req_off[0];
            end
            default: illegal = 1'b1;
        endcase
        if (is_load == is_store)
            illegal = 1'b1;
    end

    always_comb begin
        sh = rdata >> {ld_off, 3'b000};
        unique case (ld_f3)
            F3_B:    load_data = {{24{sh[7]}}, sh[7:0]};
            F3_H:    load_data = {{16{sh[15]}}, sh[15:0]};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'd0, sh[7:0]};
            F3_HU:   load_data = {16'd0, sh[15:0]};
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: handshaked data-memory port with timeout,
// returning aligned, extended load data to write-back.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr,
    output logic        resp_valid,
    output logic [1:0]  resp_err,
    output logic [31:0] load_data,
    output logic [4:0]  resp_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t      state, state_n;
    logic [15:0] cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        ld_q;
    logic [3:0]  a_wstrb;
    logic [31:0] a_wdata;
    logic [31:0] a_ldata;
    logic        mis;
    logic        ill;
    logic        accept;
    logic        timeout;

    lsu_align u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .req_f3     (funct3),
        .req_off    (addr[1:0]),
        .store_data (store_data),
        .ld_f3      (f3_q),
        .ld_off     (off_q),
        .rdata      (mem_rdata),
        .wstrb      (a_wstrb),
        .wdata      (a_wdata),
        .load_data  (a_ldata),
        .misaligned (mis),
        .illegal    (ill)
    );

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign mem_req    = (state == WAIT);
    assign accept     = req_valid && req_ready;
    // Fires on the last permitted wait cycle; an ack there still wins.
    assign timeout    = (cnt == 16'(MEM_TIMEOUT - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = (ill || mis) ? RESP : WAIT;
            WAIT:    if (mem_ack || timeout) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            ld_q      <= 1'b0;
            resp_err  <= ERR_OK;
            load_data <= 32'd0;
            resp_rd   <= 5'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: if (accept) begin
                    cnt       <= 16'd0;
                    f3_q      <= funct3;
                    off_q     <= addr[1:0];
                    ld_q      <= is_load;
                    load_data <= 32'd0;
                    resp_rd   <= (is_load && !ill) ? rd_addr : 5'd0;
                    resp_err  <= ill ? ERR_ILLEGAL
                               : mis ? ERR_MISALIGN : ERR_OK;
                    if (!ill && !mis) begin
                        mem_we    <= is_store;
                        mem_addr  <= addr[31:2];
                        mem_wstrb <= is_store ? a_wstrb : 4'd0;
                        mem_wdata <= is_store ? a_wdata : 32'd0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (mem_ack) begin
                        if (ld_q) load_data <= a_ldata;
                    end else if (timeout) begin
                        resp_err <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed scoreboard bench for the load/store unit.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] load_data;
    logic [4:0]  resp_rd;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    lsu #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd_addr    (rd_addr),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .load_data  (load_data),
        .resp_rd    (resp_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(logic ld, logic st, logic [2:0] f3,
                         logic [31:0] a, logic [31:0] sd, logic [4:0] rd,
                         logic [1:0] e_err, logic [31:0] e_data,
                         logic [4:0] e_rd);
        exp_t e;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'd1);
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        rd_addr    = rd;
        req_valid  = 1'b1;
        e.err  = e_err;
        e.data = e_data;
        e.rd   = e_rd;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic serve(int d, logic [31:0] rdata, logic we,
                         logic [29:0] ma, logic [3:0] st,
                         logic [31:0] wd);
        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            chk("mem_req", 32'(mem_req), 32'd1);
            chk("mem_we", 32'(mem_we), 32'(we));
            chk("mem_addr", 32'(mem_addr), 32'(ma));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(st));
            chk("mem_wdata", mem_wdata, wd);
            if (i == d) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
    endtask

    task automatic expect_resp();
        exp_t e;
        @(negedge clk);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("mem_req_low", 32'(mem_req), 32'd0);
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("load_data", load_data, e.data);
            if (e.err == ERR_OK)
                chk("resp_rd", 32'(resp_rd), 32'(e.rd));
        end
        @(negedge clk);
        chk("resp_once", 32'(resp_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'd0;
        addr       = 32'd0;
        store_data = 32'd0;
        rd_addr    = 5'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        issue(0, 1, F3_W, 32'h100, 32'hDEADBEEF, 5'd3, ERR_OK, 0, 0);
        serve(3, 32'h0, 1, 30'h40, 4'b1111, 32'hDEADBEEF);
        expect_resp();

        issue(1, 0, F3_B, 32'h201, 0, 5'd5, ERR_OK, 32'h7F, 5'd5);
        serve(1, 32'h80FF7F01, 0, 30'h80, 4'd0, 32'd0);
        expect_resp();
        issue(1, 0, F3_B, 32'h202, 0, 5'd6, ERR_OK, 32'hFFFFFFFF, 5'd6);
        serve(1, 32'h80FF7F01, 0, 30'h80, 4'd0, 32'd0);
        expect_resp();
        issue(1, 0, F3_BU, 32'h203, 0, 5'd7, ERR_OK, 32'h80, 5'd7);
        serve(1, 32'h80FF7F01, 0, 30'h80, 4'd0, 32'd0);
        expect_resp();
        issue(1, 0, F3_H, 32'h202, 0, 5'd8, ERR_OK, 32'hFFFF80FF, 5'd8);
        serve(1, 32'h80FF7F01, 0, 30'h80, 4'd0, 32'd0);
        expect_resp();
        issue(1, 0, F3_HU, 32'h202, 0, 5'd9, ERR_OK, 32'h80FF, 5'd9);
        serve(1, 32'h80FF7F01, 0, 30'h80, 4'd0, 32'd0);
        expect_resp();

        issue(0, 1, F3_B, 32'h103, 32'hAB, 5'd1, ERR_OK, 0, 0);
        serve(1, 32'h0, 1, 30'h40, 4'b1000, 32'hABABABAB);
        expect_resp();
        issue(0, 1, F3_H, 32'h102, 32'h1234, 5'd1, ERR_OK, 0, 0);
        serve(2, 32'h0, 1, 30'h40, 4'b1100, 32'h12341234);
        expect_resp();

        issue(1, 0, F3_W, 32'h102, 0, 5'd4, ERR_MISALIGN, 0, 0);
        expect_resp();
        issue(1, 0, 3'b011, 32'h100, 0, 5'd4, ERR_ILLEGAL, 0, 0);
        expect_resp();
        issue(0, 1, F3_BU, 32'h100, 0, 5'd4, ERR_ILLEGAL, 0, 0);
        expect_resp();

        issue(1, 0, F3_W, 32'h300, 0, 5'd10, ERR_TIMEOUT, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_mem_req", 32'(mem_req), 32'd1);
        end
        expect_resp();

        issue(1, 0, F3_W, 32'h300, 0, 5'd11, ERR_OK, 32'h12345678, 5'd11);
        serve(4, 32'h12345678, 0, 30'hC0, 4'd0, 32'd0);
        expect_resp();

        issue(1, 0, F3_W, 32'h400, 0, 5'd12, ERR_OK, 0, 0);
        @(negedge clk);
        chk("rs_wait1", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("rs_wait2", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_mem_req", 32'(mem_req), 32'd0);
        chk("rs_resp", 32'(resp_valid), 32'd0);
        chk("rs_ready_low", 32'(req_ready), 32'd0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        @(negedge clk);
        chk("rs_ready", 32'(req_ready), 32'd1);
        chk("rs_no_resp", 32'(resp_valid), 32'd0);
        chk("rs_no_req", 32'(mem_req), 32'd0);
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        @(negedge clk);
        chk("rs_late_ack", 32'(resp_valid), 32'd0);
        sb.delete();

        issue(1, 0, F3_W, 32'h404, 0, 5'd13, ERR_OK, 32'hCAFEF00D, 5'd13);
        serve(1, 32'hCAFEF00D, 0, 30'h101, 4'd0, 32'd0);
        expect_resp();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
